dlx_exec_unit: RTL
==================

# dlx_exec_unit

Parametrised execute stage for the DLX pipeline, successor to the fixed 32-bit stage-2 ALU. Performs arithmetic, logic, shift, load-extend and a multi-cycle serial multiply on WIDTH-bit operands. Results and a full flag set are returned over a valid/ready handshake, so the stage can stall upstream and absorb downstream backpressure. Sits between decode/operand fetch and memory/writeback.

## Interface
- WIDTH, 32, operand/result width; even, ≥ 16
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts operation this cycle
- op  in  4  operation code (dlx_exec_pkg::op_t)
- a  in  WIDTH  operand 1 (shift source, subtrahend)
- b  in  WIDTH  operand 2 (minuend, load data)
- shamt  in  SHW  shift amount
- out_valid  out  1  result register holds unconsumed result
- out_ready  in  1  downstream consumes result
- result  out  WIDTH  result
- carry, zero, neg, ovf  out  1 each  flags

## Operation
- Codes: ADD 0, HADD 1, SUB 2, NOT 3, AND 4, OR 5, XOR 6, LHG 7, SLL 8, SRL 9, SRA 10, MUL 11, LB 12, LBU 13, LH 14, LHU 15.
- ADD: a+b; carry = unsigned carry-out; ovf = signed overflow.
- HADD: low halves added; result = sign-extended half sum; carry = half carry-out; ovf 0.
- SUB: b−a; carry = 1 on unsigned borrow; ovf = signed overflow.
- NOT: ~b. AND/OR/XOR: bitwise a,b. LHG: {b[WIDTH/2-1:0], zeros}.
- SLL/SRL: a shifted logically by shamt. SRA: arithmetic shift of a.
- LB/LBU: b[7:0] sign/zero-extended. LH/LHU: b[15:0] sign/zero-extended.
- MUL: unsigned a×b, shift-add over WIDTH iterations; result = low WIDTH bits; carry = OR of high WIDTH bits; ovf 0.
- Flags for all ops: zero = (result==0), neg = result[WIDTH-1]; carry/ovf 0 where not defined above.
- FSM states: IDLE, MUL_BUSY. Accept (in_valid && in_ready) of MUL in IDLE → MUL_BUSY, iteration counter loaded with WIDTH; counter reaching 0 → result register loaded, out_valid=1, → IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Result register loads only on accept (single-cycle ops) or MUL completion; holds otherwise.

## Timing
- Reset (rst low, async): state IDLE, counter 0, result 0, all flags 0, out_valid 0; in_ready 1 after reset release.
- Single-cycle ops: accepted at edge N → out_valid, result, flags valid after edge N (latency 1).
- MUL: accepted at edge N → out_valid after edge N+WIDTH (latency WIDTH); in_ready 0 throughout.
- Back-to-back: result consumed and new op accepted in same cycle → no bubble, out_valid stays 1.
- out_valid && !out_ready: result/flags stable, in_ready 0, no accept.
- out_valid falls the edge after consume when no new accept.
- MUL completion while previous result unconsumed is impossible (MUL accepted only with slot free or being consumed).
- rst asserted mid-MUL: operation discarded, no result emitted.
- shamt ≥ WIDTH unreachable by width; shamt 0 passes a unchanged.

## Structure
- dlx_exec_pkg: op_t enum (4-bit codes above), state_t enum (IDLE, MUL_BUSY).
- Sub-module dlx_serial_mul: start/busy/done handshake, WIDTH-parametrised shift-add multiplier with 2·WIDTH product; the unit instantiates one.
- Top holds FSM, single-cycle datapath, result/flag register, handshake.

## Test plan
- ADD a=0xFFFFFFFF b=0x00000001 → result 0, carry 1, zero 1, ovf 0, out_valid one cycle after accept.
- SUB a=0x00000001 b=0x80000000 → result 0x7FFFFFFF, ovf 1, carry 0; then HADD a=0x0000FFFF b=0x00000001 → result 0, carry 1.
- SRA a=0x80000000 shamt=4 → 0xF8000000, neg 1; LB b=0x00000080 → 0xFFFFFF80; LHU b=0x0001_8000 → 0x00008000.
- MUL a=0x00010000 b=0x00010000 → result 0, carry 1, zero 1; out_valid exactly 32 cycles after accept, in_ready 0 during.
- Backpressure: out_ready 0 for 5 cycles after ADD 3+4 → result 7 held, in_ready 0; out_ready 1 with new op waiting → accepted same cycle, no bubble.
- rst pulsed low 10 cycles into MUL → out_valid 0, result 0 immediately; next ADD 1+1 returns 2 with latency 1.

Source files
------------

// File: rtl/dlx_exec_pkg.sv
// Shared types for the DLX execute stage: opcodes, FSM states, flag bundle.
package dlx_exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_HADD = 4'd1,
    OP_SUB  = 4'd2,
    OP_NOT  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_LHG  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11,
    OP_LB   = 4'd12,
    OP_LBU  = 4'd13,
    OP_LH   = 4'd14,
    OP_LHU  = 4'd15
  } op_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/dlx_exec_unit_mul.sv
// Serial shift-add multiplier: one partial product per cycle, WIDTH cycles.
// product_o carries the next accumulator value so the final sum is usable
// in the same cycle done_o is high.
module dlx_serial_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy_o    = (cnt_q != '0);
  assign done_o    = (cnt_q == CW'(1));
  assign product_o = acc_d;

  // Load operands on start, then add/shift once per cycle until the count expires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      cnt_q    <= CW'(WIDTH);
    end else if (busy_o) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/dlx_exec_unit.sv
// DLX execute stage: single-cycle ALU/shift/load-extend plus serial MUL,
// with a one-entry result register behind a valid/ready handshake.
module dlx_exec_unit
  import dlx_exec_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q, zero_q, neg_q, ovf_q, ovalid_q;

  logic               accept, mul_start, alu_load, load;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum, diff;
  logic [H:0]         hsum;
  logic [WIDTH-1:0]   alu_res, res_d;
  logic               alu_c, alu_v, c_d, v_d;

  assign in_ready  = (state_q == IDLE) && !mul_busy && (!ovalid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);
  assign alu_load  = accept && (op != OP_MUL);
  assign load      = alu_load || mul_done;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, b} - {1'b0, a};
  assign hsum = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]};

  dlx_serial_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Single-cycle datapath; diff[WIDTH] is the unsigned borrow of b-a.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD:  begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_HADD: begin
        alu_res = WIDTH'($signed(hsum[H-1:0]));
        alu_c   = hsum[H];
      end
      OP_SUB:  begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != b[WIDTH-1]);
      end
      OP_NOT:  alu_res = ~b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_LHG:  alu_res = {b[H-1:0], {H{1'b0}}};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_LB:   alu_res = WIDTH'($signed(b[7:0]));
      OP_LBU:  alu_res = WIDTH'(b[7:0]);
      OP_LH:   alu_res = WIDTH'($signed(b[15:0]));
      OP_LHU:  alu_res = WIDTH'(b[15:0]);
      default: alu_res = '0;
    endcase
  end

  // Result source: multiplier on completion, otherwise the ALU.
  always_comb begin
    res_d = alu_res;
    c_d   = alu_c;
    v_d   = alu_v;
    if (mul_done) begin
      res_d = mul_prod[WIDTH-1:0];
      c_d   = |mul_prod[2*WIDTH-1:WIDTH];
      v_d   = 1'b0;
    end
  end

  // Control FSM: IDLE accepts ops, MUL_BUSY blocks input until the multiplier finishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (mul_start) begin
          state_q <= MUL_BUSY;
          cnt_q   <= CW'(WIDTH);
        end
        MUL_BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (mul_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Result/flag register and output valid; holds while unconsumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ovalid_q <= 1'b0;
    end else if (load) begin
      res_q    <= res_d;
      carry_q  <= c_d;
      zero_q   <= (res_d == '0);
      neg_q    <= res_d[WIDTH-1];
      ovf_q    <= v_d;
      ovalid_q <= 1'b1;
    end else if (out_ready) begin
      ovalid_q <= 1'b0;
    end
  end

  assign out_valid = ovalid_q;
  assign result    = res_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule
